// File: rtl/cnna_prod_accum_pkg.sv
// Shared types, widths and the shift/saturate helper for the product accumulator
// and the requantise stages that follow it.
package cnna_acc_pkg;

  localparam int unsigned DIN_W   = 35;
  localparam int unsigned ACC_W   = 48;
  localparam int unsigned DOUT_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SHIFT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic              sat;
    logic [DOUT_W-1:0] data;
  } result_t;

  // Logical right shift, then clip to DOUT_W; shifts of ACC_W or more give zero.
  function automatic result_t sat_shift(input logic [ACC_W-1:0]   acc,
                                        input logic [SHIFT_W-1:0] shift);
    logic [ACC_W-1:0] r;
    result_t          res;
    r = (32'(shift) >= ACC_W) ? '0 : (acc >> shift);
    if (|r[ACC_W-1:DOUT_W]) begin
      res.sat  = 1'b1;
      res.data = '1;
    end else begin
      res.sat  = 1'b0;
      res.data = r[DOUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cnna_prod_accum_if.sv
// Config, product-in and sum-out handshake bundle of the product accumulator.
interface cnna_prod_accum_if;
  import cnna_acc_pkg::*;

  logic [CNT_W-1:0]   cfg_len;
  logic [SHIFT_W-1:0] cfg_shift;
  logic [DIN_W-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DOUT_W-1:0]  out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport slave (
    input  cfg_len, cfg_shift, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid, busy
  );

  modport master (
    output cfg_len, cfg_shift, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid, busy
  );

endinterface

// File: rtl/cnna_prod_accum_satshift.sv
// Combinational shift-and-saturate of an accumulator value down to the output width.
module cnna_acc_satshift
  import cnna_acc_pkg::*;
(
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output result_t            res_o
);

  assign res_o = sat_shift(acc_i, shift_i);

endmodule

// File: rtl/cnna_prod_accum.sv
// Accumulates groups of cfg_len unsigned products into one shifted, saturated sum
// presented on a valid/ready output; a new group may start in the same cycle a result leaves.
module cnna_prod_accum
  import cnna_acc_pkg::*;
(
  input  logic               ap_clk,
  input  logic               ap_rst,
  cnna_prod_accum_if.slave   bus
);

  state_e             state_q;
  logic               run_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               sat_q;
  logic               out_sat_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   len_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [DOUT_W-1:0]  out_data_q;

  logic               in_ready_c;
  logic               beat;
  logic               xfer;
  logic               start;
  logic               last;
  logic               carry;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   len_d;
  logic [ACC_W-1:0]   ss_acc;
  logic [SHIFT_W-1:0] ss_shift;
  result_t            res;

  // Handshake decode, saturating add, and selection of the value to be finalised.
  always_comb begin
    in_ready_c = run_q && ((state_q != HOLD) || bus.out_ready);
    beat       = bus.in_valid && in_ready_c;
    xfer       = out_valid_q && bus.out_ready;
    start      = beat && (state_q != ACC);
    len_d      = (bus.cfg_len == '0) ? CNT_W'(1) : bus.cfg_len;
    {carry, acc_d} = (ACC_W+1)'(acc_q) + (ACC_W+1)'(bus.in_data);
    if (carry) begin
      acc_d = '1;
    end
    cnt_d    = cnt_q + CNT_W'(1);
    last     = start ? (len_d == CNT_W'(1)) : (cnt_d == len_q);
    ss_acc   = start ? ACC_W'(bus.in_data) : acc_d;
    ss_shift = start ? bus.cfg_shift : shift_q;
  end

  cnna_acc_satshift u_satshift (
    .acc_i   (ss_acc),
    .shift_i (ss_shift),
    .res_o   (res)
  );

  // Group FSM with counter, accumulator and result registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
    end else begin
      run_q <= 1'b1;
      if (start) begin
        acc_q   <= ss_acc;
        sat_q   <= 1'b0;
        cnt_q   <= CNT_W'(1);
        len_q   <= len_d;
        shift_q <= bus.cfg_shift;
        busy_q  <= 1'b1;
        if (last) begin
          state_q     <= HOLD;
          out_valid_q <= 1'b1;
          out_data_q  <= res.data;
          out_sat_q   <= res.sat;
        end else begin
          state_q     <= ACC;
          out_valid_q <= 1'b0;
        end
      end else if (beat) begin
        acc_q <= acc_d;
        sat_q <= sat_q | carry;
        cnt_q <= cnt_d;
        if (last) begin
          state_q     <= HOLD;
          out_valid_q <= 1'b1;
          out_data_q  <= res.data;
          out_sat_q   <= res.sat | sat_q | carry;
        end
      end else if (xfer) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cnna_prod_accum.sv
// Bench for cnna_prod_accum: directed scenarios plus randomized groups against an
// arithmetic reference model of the group sum, shift and saturation rules.
module tb_cnna_prod_accum;
  import cnna_acc_pkg::*;

  localparam longint unsigned ACC_MAX = 64'h0000_FFFF_FFFF_FFFF;
  localparam logic [DIN_W-1:0] P_MAX  = '1;
  localparam logic [DIN_W-1:0] P_HALF = 35'h3_FFFF_FFFF;
  localparam int NG = 60;

  logic ap_clk = 1'b0;
  logic ap_rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  cnna_prod_accum_if bus();

  cnna_prod_accum dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer sum clipped at the accumulator range, then shift and clip.
  function automatic void model(input longint unsigned vals[$], input int unsigned sh,
                                output logic [31:0] d, output logic s);
    longint unsigned acc = 0;
    longint unsigned r;
    bit f = 0;
    foreach (vals[i]) begin
      acc += vals[i];
      if (acc > ACC_MAX) begin
        acc = ACC_MAX;
        f   = 1;
      end
    end
    r = (sh >= 48) ? 64'd0 : (acc >> sh);
    if (r > 64'h0000_0000_FFFF_FFFF) begin
      d = 32'hFFFF_FFFF;
      s = 1'b1;
    end else begin
      d = r[31:0];
      s = f;
    end
  endfunction

  task automatic send(input logic [DIN_W-1:0] d, output bit ok);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      #1;
      ok = (bus.in_ready === 1'b1);
      @(negedge ap_clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(output logic [31:0] d, output logic s, output bit ok);
    bus.out_ready = 1'b1;
    ok = 0;
    d  = '0;
    s  = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      #1;
      if (bus.out_valid === 1'b1) begin
        ok = 1;
        d  = bus.out_data;
        s  = bus.out_sat;
      end
      @(negedge ap_clk);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    bus.cfg_len = '0; bus.cfg_shift = '0; bus.in_data = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b exp 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 32'd0) $display("FAIL reset_out_data: got %h exp 0", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_sat !== 1'b0) $display("FAIL reset_out_sat: got %b exp 0", bus.out_sat); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", bus.busy); else n_pass++;
    ap_rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL release_in_ready: got %b exp 0", bus.in_ready); else n_pass++;
    @(negedge ap_clk);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b exp 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL post_reset_busy: got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_group4();
    logic [31:0] d; logic s; bit ok; bit all_ok = 1;
    bus.cfg_len = 16'd4; bus.cfg_shift = 6'd0; bus.out_ready = 1'b0;
    send(35'd10, ok); all_ok &= ok;
    send(35'd20, ok); all_ok &= ok;
    send(35'd30, ok); all_ok &= ok;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL g4_early_valid: got %b exp 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL g4_busy: got %b exp 1", bus.busy); else n_pass++;
    send(35'd40, ok); all_ok &= ok;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL g4_latency: got out_valid %b exp 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 32'd100 || bus.out_sat !== 1'b0) $display("FAIL g4_result: got %0d sat %b exp 100 sat 0", bus.out_data, bus.out_sat); else n_pass++;
    recv(d, s, ok); all_ok &= ok;
    n_checks++; if (d !== 32'd100) $display("FAIL g4_recv: got %0d exp 100", d); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL g4_idle: got valid %b busy %b exp 0 0", bus.out_valid, bus.busy); else n_pass++;
    n_checks++; if (!all_ok) $display("FAIL g4_handshake: got timeout exp accepted"); else n_pass++;
  endtask

  task automatic test_wide();
    logic [31:0] d; logic s; bit ok; bit all_ok = 1;
    logic [31:0] ed; logic es;
    for (int k = 0; k < 2; k++) begin
      bus.cfg_len = 16'd2;
      bus.cfg_shift = (k == 0) ? 6'd4 : 6'd0;
      ed = (k == 0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      es = (k == 0) ? 1'b0 : 1'b1;
      send(P_HALF, ok); all_ok &= ok;
      send(P_HALF, ok); all_ok &= ok;
      recv(d, s, ok); all_ok &= ok;
      n_checks++; if (d !== ed) $display("FAIL wide_data shift=%0d: got %h exp %h", bus.cfg_shift, d, ed); else n_pass++;
      n_checks++; if (s !== es) $display("FAIL wide_sat shift=%0d: got %b exp %b", bus.cfg_shift, s, es); else n_pass++;
    end
    n_checks++; if (!all_ok) $display("FAIL wide_handshake: got timeout exp accepted"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bus.cfg_len = 16'd1; bus.cfg_shift = 6'd0; bus.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.in_data = DIN_W'(k); bus.in_valid = 1'b1;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready beat %0d: got %b exp 1", k, bus.in_ready); else n_pass++;
      @(negedge ap_clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(k))
        $display("FAIL b2b_out beat %0d: got valid %b data %0d exp 1 %0d", k, bus.out_valid, bus.out_data, k);
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    @(negedge ap_clk);
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain: got %b exp 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic s; bit ok; bit all_ok = 1;
    bus.cfg_len = 16'd3; bus.cfg_shift = 6'd0; bus.out_ready = 1'b0;
    send(35'd7, ok); all_ok &= ok;
    send(35'd8, ok); all_ok &= ok;
    send(35'd9, ok); all_ok &= ok;
    bus.cfg_len = 16'd2; bus.in_data = 35'd100; bus.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd24 || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold cycle %0d: got valid %b data %0d ready %b exp 1 24 0", c, bus.out_valid, bus.out_data, bus.in_ready);
      else n_pass++;
      @(negedge ap_clk);
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b exp 1", bus.in_ready); else n_pass++;
    @(negedge ap_clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) $display("FAIL bp_newgroup: got valid %b busy %b exp 0 1", bus.out_valid, bus.busy); else n_pass++;
    send(35'd5, ok); all_ok &= ok;
    recv(d, s, ok); all_ok &= ok;
    n_checks++; if (d !== 32'd105 || s !== 1'b0) $display("FAIL bp_next_result: got %0d sat %b exp 105 sat 0", d, s); else n_pass++;
    n_checks++; if (!all_ok) $display("FAIL bp_handshake: got timeout exp accepted"); else n_pass++;
  endtask

  task automatic test_len0();
    logic [31:0] d; logic s; bit ok; bit all_ok = 1;
    bus.cfg_len = 16'd0; bus.cfg_shift = 6'd1; bus.out_ready = 1'b0;
    send(35'd42, ok); all_ok &= ok;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL len0_valid: got %b exp 1", bus.out_valid); else n_pass++;
    recv(d, s, ok); all_ok &= ok;
    n_checks++; if (d !== 32'd21 || s !== 1'b0) $display("FAIL len0_result: got %0d sat %b exp 21 sat 0", d, s); else n_pass++;
    n_checks++; if (!all_ok) $display("FAIL len0_handshake: got timeout exp accepted"); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic s; bit ok; bit all_ok = 1;
    bus.cfg_len = 16'd3; bus.cfg_shift = 6'd0; bus.out_ready = 1'b0;
    send(35'd1000, ok); all_ok &= ok;
    send(35'd2000, ok); all_ok &= ok;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL mid_busy: got %b exp 1", bus.busy); else n_pass++;
    ap_rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL mid_async_reset: got busy %b ready %b valid %b exp 0 0 0", bus.busy, bus.in_ready, bus.out_valid);
    else n_pass++;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    send(35'd1, ok); all_ok &= ok;
    send(35'd1, ok); all_ok &= ok;
    send(35'd1, ok); all_ok &= ok;
    recv(d, s, ok); all_ok &= ok;
    n_checks++; if (d !== 32'd3 || s !== 1'b0) $display("FAIL mid_fresh_sum: got %0d sat %b exp 3 sat 0", d, s); else n_pass++;
    n_checks++; if (!all_ok) $display("FAIL mid_handshake: got timeout exp accepted"); else n_pass++;
  endtask

  task automatic test_acc_sat();
    logic [31:0] d; logic s; bit ok; bit all_ok = 1;
    logic [31:0] ed; logic es;
    longint unsigned vals[$];
    int n;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 8192 : 8194;
      vals.delete();
      for (int i = 0; i < n; i++) vals.push_back(64'(P_MAX));
      model(vals, 16, ed, es);
      bus.cfg_len = 16'(n); bus.cfg_shift = 6'd16; bus.out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
        send(P_MAX, ok); all_ok &= ok;
      end
      recv(d, s, ok); all_ok &= ok;
      n_checks++; if (d !== ed || s !== es) $display("FAIL acc_sat n=%0d: got %h sat %b exp %h sat %b", n, d, s, ed, es); else n_pass++;
    end
    n_checks++; if (!all_ok) $display("FAIL acc_sat_handshake: got timeout exp accepted"); else n_pass++;
  endtask

  task automatic test_random();
    logic [32:0] exp_q[$];
    bit all_ok = 1;
    int got = 0;
    fork
      begin : driver
        longint unsigned vals[$];
        logic [DIN_W-1:0] p;
        logic [31:0] ed; logic es;
        bit ok;
        int len, n, sh;
        for (int g = 0; g < NG; g++) begin
          len = $urandom_range(0, 6);
          n   = (len == 0) ? 1 : len;
          sh  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 12);
          vals.delete();
          for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 2))
              0:       p = DIN_W'($urandom_range(0, 1000));
              1:       p = DIN_W'({$urandom, $urandom});
              default: p = P_MAX;
            endcase
            vals.push_back(64'(p));
          end
          model(vals, sh, ed, es);
          exp_q.push_back({es, ed});
          for (int k = 0; k < n; k++) begin
            bus.cfg_len   = (k == 0) ? 16'(len) : 16'($urandom);
            bus.cfg_shift = (k == 0) ? 6'(sh) : 6'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge ap_clk);
            send(DIN_W'(vals[k]), ok);
            all_ok &= ok;
          end
        end
      end
      begin : consumer
        logic [32:0] e;
        for (int c = 0; c < 20000 && got < NG; c++) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          #1;
          if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              $display("FAIL rand_unexpected: got %h sat %b exp no result", bus.out_data, bus.out_sat);
            end else begin
              e = exp_q.pop_front();
              if ({bus.out_sat, bus.out_data} !== e)
                $display("FAIL rand_result %0d: got %h sat %b exp %h sat %b", got, bus.out_data, bus.out_sat, e[31:0], e[32]);
              else n_pass++;
            end
            got++;
          end
          @(negedge ap_clk);
        end
        bus.out_ready = 1'b0;
      end
    join
    n_checks++; if (got != NG) $display("FAIL rand_count: got %0d exp %0d", got, NG); else n_pass++;
    n_checks++; if (!all_ok) $display("FAIL rand_handshake: got timeout exp accepted"); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_group4();
    test_wide();
    test_back_to_back();
    test_backpressure();
    test_len0();
    test_reset_mid();
    test_acc_sat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
